// File: rtl/flag_stack_unit.sv
// Status-flag register with per-bit write mask, sticky accumulating bits and
// a bounded save/restore stack for interrupt/call context.
module flag_stack_unit #(
  parameter int              WIDTH       = 32,
  parameter int              DEPTH       = 4,
  parameter logic [WIDTH-1:0] STICKY_MASK = 32'h0000_0008,
  parameter logic [WIDTH-1:0] RST_VAL     = 32'h0,
  localparam int             DW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rw,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] new_flag,
  input  logic             sticky_clr,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [WIDTH-1:0] flag,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             stk_err
);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] wen;
  logic             do_push;
  logic             do_pop;
  logic             err_evt;

  // Sticky bits OR in new set events; a same-cycle set beats the clear.
  function automatic logic [WIDTH-1:0] upd_flags(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] we,
                                                 input logic [WIDTH-1:0] nv,
                                                 input logic             clr);
    logic [WIDTH-1:0] keep;
    keep = clr ? (cur & ~STICKY_MASK) : cur;
    return (~STICKY_MASK & ((we & nv) | (~we & cur))) |
           ( STICKY_MASK & (keep | (we & nv)));
  endfunction

  assign full    = (depth == DW'(DEPTH));
  assign empty   = (depth == '0);
  assign wen     = {WIDTH{~rw}} & mask;
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign err_evt = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (depth == DW'(i + 1)) top = stack[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag    <= RST_VAL;
      depth   <= '0;
      stk_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      flag <= do_pop ? top : upd_flags(flag, wen, new_flag, sticky_clr);
      if (do_push) depth <= depth + DW'(1);
      else if (do_pop) depth <= depth - DW'(1);
      // The saved copy is the pre-edge flag, so a concurrent write is excluded.
      for (int i = 0; i < DEPTH; i++)
        if (do_push && depth == DW'(i)) stack[i] <= flag;
      if (err_evt) stk_err <= 1'b1;
      else if (err_clr) stk_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flag_stack_unit.sv
// Bench for flag_stack_unit: vector table plus hand-written reset sequences,
// with expected outputs queued at drive time and compared after each edge.
module tb_flag_stack_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rw = 1'b1;
  logic [WIDTH-1:0] mask = '0;
  logic [WIDTH-1:0] new_flag = '0;
  logic             sticky_clr = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] flag;
  logic [DW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             stk_err;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic             rw;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] nf;
    logic             sc;
    logic             pu;
    logic             po;
    logic             ec;
    logic [WIDTH-1:0] e_flag;
    int               e_depth;
    logic             e_err;
  } vec_t;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] flag;
    int               depth;
    logic             err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  flag_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rw(rw), .mask(mask), .new_flag(new_flag),
    .sticky_clr(sticky_clr), .push(push), .pop(pop), .err_clr(err_clr),
    .flag(flag), .depth(depth), .full(full), .empty(empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (got no finish, required finish)");
    $fatal(1, "timeout");
  end

  task automatic check(input exp_t e);
    logic e_full, e_empty;
    e_full  = (e.depth == DEPTH);
    e_empty = (e.depth == 0);
    n_vec++;
    if (flag !== e.flag || int'(depth) != e.depth || full !== e_full ||
        empty !== e_empty || stk_err !== e.err) begin
      n_fail++;
      $display("FAIL %s: got flag=%h depth=%0d full=%b empty=%b err=%b, want flag=%h depth=%0d full=%b empty=%b err=%b",
               e.name, flag, depth, full, empty, stk_err,
               e.flag, e.depth, e_full, e_empty, e.err);
    end
  endtask

  task automatic add(input logic r, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] n,
                     input logic sc, input logic pu, input logic po, input logic ec,
                     input logic [WIDTH-1:0] ef, input int ed, input logic ee);
    vec_t v;
    v.rw = r; v.mask = m; v.nf = n; v.sc = sc; v.pu = pu; v.po = po; v.ec = ec;
    v.e_flag = ef; v.e_depth = ed; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    rw = v.rw; mask = v.mask; new_flag = v.nf; sticky_clr = v.sc;
    push = v.pu; pop = v.po; err_clr = v.ec;
    e.name = name; e.flag = v.e_flag; e.depth = v.e_depth; e.err = v.e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(sb.pop_front());
  endtask

  task automatic async_reset_check(input string name);
    exp_t e;
    #2;
    rst = 1'b0;
    #1;
    e.name = name; e.flag = '0; e.depth = 0; e.err = 1'b0;
    check(e);
    @(negedge clk);
    rw = 1'b1; mask = '0; new_flag = '0; sticky_clr = 1'b0;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    //   rw mask          new_flag      sc pu po ec  exp_flag      d  err
    add(0, 32'h1F,       32'h13,       0, 0, 0, 0, 32'h13,       0, 0);
    add(0, 32'h03,       32'h0,        0, 0, 0, 0, 32'h10,       0, 0);
    add(0, 32'hFFFFFFFF, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    add(0, 32'h08,       32'h8,        0, 0, 0, 0, 32'h8,        0, 0);
    add(0, 32'hFFFFFFFF, 32'h0,        0, 0, 0, 0, 32'h8,        0, 0);
    add(1, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        0, 0);
    add(0, 32'h08,       32'h8,        1, 0, 0, 0, 32'h8,        0, 0);
    add(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h8,        0, 0);
    add(0, 32'hFFFFFFFF, 32'h5,        1, 0, 0, 0, 32'h5,        0, 0);
    add(0, 32'h07,       32'h2,        0, 1, 0, 0, 32'h2,        1, 0);
    add(1, 32'h0,        32'h0,        0, 0, 1, 0, 32'h5,        0, 0);
    add(1, 32'h0,        32'h0,        0, 1, 0, 0, 32'h5,        1, 0);
    add(0, 32'h1F,       32'h10,       0, 1, 0, 0, 32'h10,       2, 0);
    add(0, 32'hFFFFFFFF, 32'h80000001, 0, 1, 0, 0, 32'h80000001, 3, 0);
    add(1, 32'h0,        32'h0,        0, 1, 0, 0, 32'h80000001, 4, 0);
    add(0, 32'h01,       32'h0,        0, 1, 0, 0, 32'h80000000, 4, 1);
    add(1, 32'h0,        32'h0,        0, 0, 0, 1, 32'h80000000, 4, 0);
    add(1, 32'h0,        32'h0,        0, 1, 0, 1, 32'h80000000, 4, 1);
    add(1, 32'h0,        32'h0,        0, 0, 0, 1, 32'h80000000, 4, 0);
    add(0, 32'hFFFFFFFF, 32'h0,        1, 0, 1, 0, 32'h80000001, 3, 0);
    add(1, 32'h0,        32'h0,        0, 0, 1, 0, 32'h10,       2, 0);
    add(1, 32'h0,        32'h0,        0, 1, 1, 0, 32'h10,       2, 1);
    add(0, 32'h01,       32'h1,        0, 0, 0, 1, 32'h11,       2, 0);
    add(1, 32'h0,        32'h0,        0, 0, 1, 0, 32'h5,        1, 0);
    add(1, 32'h0,        32'h0,        0, 0, 1, 0, 32'h5,        0, 0);
    add(0, 32'h01,       32'h0,        0, 0, 1, 0, 32'h4,        0, 1);

    async_reset_check("reset_initial");

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Flags are 4 with stk_err set here, so a working async clear is visible.
    @(posedge clk);
    async_reset_check("reset_mid_run");

    begin
      vec_t v;
      v.rw = 0; v.mask = 32'h3; v.nf = 32'h3; v.sc = 0; v.pu = 1; v.po = 0; v.ec = 0;
      v.e_flag = 32'h3; v.e_depth = 1; v.e_err = 0;
      apply(v, "seq_push1");
      v.rw = 1; v.e_depth = 2;
      apply(v, "seq_push2");
      v.po = 1;
      v.e_err = 1;
      apply(v, "seq_push_pop");
      @(posedge clk);
      async_reset_check("seq_reset_after_err");
      v.pu = 0; v.po = 1; v.e_flag = 32'h0; v.e_depth = 0; v.e_err = 1;
      apply(v, "seq_pop_after_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
